// File: rtl/palette_fade_lut.sv
// palette_fade_lut: palette lookup with two-stage read pipeline and timed fade-in/fade-out level scaling
module palette_fade_lut #(
  parameter int IDX_W       = 4,
  parameter int COL_W       = 4,
  parameter int LVL_W       = 4,
  parameter int STEP_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [3*COL_W-1:0] wr_rgb,
  input  logic               pix_valid,
  input  logic [IDX_W-1:0]   index,
  input  logic               fade_start,
  input  logic               fade_dir,
  output logic [COL_W-1:0]   red,
  output logic [COL_W-1:0]   green,
  output logic [COL_W-1:0]   blue,
  output logic               out_valid,
  output logic               fade_busy,
  output logic               fade_done,
  output logic [LVL_W-1:0]   level
);
  localparam int DEPTH = 2**IDX_W;
  localparam int CNT_W = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam int PW = COL_W + LVL_W;
  localparam logic [LVL_W-1:0] LMAX = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FADING, DONE} state_t;

  state_t             state, state_n;
  logic [LVL_W-1:0]   level_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               tgt, tgt_n;
  logic [LVL_W-1:0]   tgt_lvl, start_lvl, stepped;
  logic [3*COL_W-1:0] mem [DEPTH];
  logic [3*COL_W-1:0] s1_rgb;
  logic [LVL_W-1:0]   s1_lvl;
  logic               s1_v;

  // Level 0 blanks, LMAX passes through, anything between scales by (level+1)/2**LVL_W.
  function automatic logic [COL_W-1:0] scale(input logic [COL_W-1:0] c, input logic [LVL_W-1:0] l);
    logic [PW-1:0] p;
    p = PW'(c) * (PW'(l) + PW'(1));
    return l == '0 ? '0 : COL_W'(p >> LVL_W);
  endfunction

  assign tgt_lvl   = tgt ? LMAX : '0;
  assign start_lvl = fade_dir ? LMAX : '0;
  assign stepped   = tgt ? level + LVL_W'(1) : level - LVL_W'(1);
  assign fade_busy = state == FADING;
  assign fade_done = state == DONE;

  // Fade sequencing: latch direction on start, step one level per STEP_CYCLES while fading.
  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n   = cnt;
    tgt_n   = tgt;
    case (state)
      IDLE: if (fade_start) begin
        tgt_n   = fade_dir;
        cnt_n   = '0;
        state_n = level == start_lvl ? DONE : FADING;
      end
      FADING: if (cnt == CNT_LAST) begin
        cnt_n   = '0;
        level_n = level == tgt_lvl ? level : stepped;
        state_n = level_n == tgt_lvl ? DONE : FADING;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Fade state registers; reset abandons any fade and returns to full brightness.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      level <= LMAX;
      cnt   <= '0;
      tgt   <= 1'b1;
    end else begin
      state <= state_n;
      level <= level_n;
      cnt   <= cnt_n;
      tgt   <= tgt_n;
    end
  end

  // Palette storage; the read stage samples the pre-write contents on a write edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_rgb;
    end
  end

  // Two-stage read pipeline; the level travels with the entry so a pixel never mixes levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rgb    <= '0;
      s1_lvl    <= LMAX;
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      s1_rgb    <= mem[index];
      s1_lvl    <= level;
      s1_v      <= pix_valid;
      out_valid <= s1_v;
      red       <= scale(s1_rgb[3*COL_W-1 -: COL_W], s1_lvl);
      green     <= scale(s1_rgb[2*COL_W-1 -: COL_W], s1_lvl);
      blue      <= scale(s1_rgb[COL_W-1:0], s1_lvl);
    end
  end
endmodule

// File: doc/palette_fade_lut.md
PALETTE_FADE_LUT -- requirements
Module: palette_fade_lut

Interface
REQ-001 Parameter IDX_W, default 4, palette index width; the table SHALL hold 2**IDX_W entries.
REQ-002 Parameter COL_W, default 4, width of each of the red, green and blue channels.
REQ-003 Parameter LVL_W, default 4, fade level width; LMAX = 2**LVL_W-1.
REQ-004 Parameter STEP_CYCLES, default 1024, clock cycles per fade level step; legal range >=1.
REQ-005 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  palette write strobe.
REQ-008 wr_idx  input  IDX_W  entry to write.
REQ-009 wr_rgb  input  3*COL_W  {red,green,blue} write data.
REQ-010 pix_valid  input  1  qualifies index.
REQ-011 index  input  IDX_W  palette lookup index.
REQ-012 fade_start  input  1  single-cycle fade request.
REQ-013 fade_dir  input  1  0 = fade out toward level 0, 1 = fade in toward LMAX; sampled with fade_start.
REQ-014 red, green, blue  output  COL_W each  scaled colour, registered.
REQ-015 out_valid  output  1  pix_valid delayed by 2 cycles.
REQ-016 fade_busy  output  1  high in state FADING.
REQ-017 fade_done  output  1  single-cycle pulse in state DONE.
REQ-018 level  output  LVL_W  current fade level.

Function
REQ-019 Read pipeline SHALL have fixed latency 2: stage 1 registers the table entry at index; stage 2 registers the scaled colour.
REQ-020 Every pixel cycle SHALL advance the pipeline; there is no stall; out_valid SHALL be pix_valid delayed 2 cycles.
REQ-021 Stage-1 data SHALL be registered regardless of pix_valid; red/green/blue when out_valid=0 are don't-care but SHALL be deterministic.
REQ-022 Scaling per channel: level==0 -> 0; otherwise (c*(level+1))>>LVL_W, computed at COL_W+LVL_W bits, truncated to COL_W; level==LMAX SHALL return c unchanged.
REQ-023 Stage 2 SHALL use the level value registered in the same cycle stage 1 data is registered, so one pixel never mixes two levels across channels.
REQ-024 A write SHALL update the entry on the edge where wr_en=1; a same-cycle read of the same index SHALL return the old value (read-before-write); the next cycle returns the new value.
REQ-025 Fade FSM states: IDLE, FADING, DONE.
REQ-026 IDLE: fade_start=1 latches fade_dir as target (0 or LMAX) and clears the step counter; if level already equals the target -> DONE, else -> FADING.
REQ-027 FADING: step counter counts 0..STEP_CYCLES-1; at terminal count level moves one toward the target and the counter wraps to 0; when the updated level equals the target -> DONE.
REQ-028 DONE: fade_done=1 for exactly one cycle, then -> IDLE.
REQ-029 fade_start in FADING or DONE SHALL be ignored (no retarget, no counter clear).
REQ-030 level SHALL never wrap below 0 or above LMAX.
REQ-031 Palette writes and pixel reads SHALL be fully independent of FSM state.

Reset
REQ-032 Reset SHALL force: FSM IDLE, level=LMAX, step counter 0, fade_busy=0, fade_done=0, out_valid and both pipeline valid stages 0, red/green/blue=0, all palette entries 0.
REQ-033 Reset mid-fade SHALL abandon the fade with no fade_done pulse; reset SHALL take priority over wr_en and fade_start in the same cycle.

Verification
REQ-034 Write idx 3 = {5,2,0}; read idx 3 with pix_valid=1 -> 2 cycles later out_valid=1, rgb={5,2,0} at level 15.
REQ-035 Same-cycle write idx 7 = {F,F,F} (old {0,0,0}) and read idx 7 -> {0,0,0}; read next cycle -> {F,F,F}.
REQ-036 STEP_CYCLES=4, fade_start with dir=0 from level 15 -> level decrements every 4 cycles, fade_busy high for 60 cycles, single fade_done when level=0, entry {C,C,C} output as {0,0,0}.
REQ-037 Level 7, entry {F,8,1} -> output {7,4,0}; fade_start dir=1 at level 15 -> DONE next cycle, one fade_done pulse, level stays 15.
REQ-038 Reset asserted at level 9 during FADING -> next cycle IDLE, level 15, fade_busy 0, no fade_done, all entries read back 0.
REQ-039 fade_start dir=1 pulsed during a fade-out -> ignored; fade completes at level 0 with one fade_done.
